// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: FSM encoding, next-PC select codes and PC constants.
package if_fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK    = 32'h0000_0003;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_SEL_HOLD     = 2'd0,
        PC_SEL_INC      = 2'd1,
        PC_SEL_REDIRECT = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response channel plus the fetch-to-decode handshake.
interface if_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] pc_if;
    logic [31:0] inst_if;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, pc_if, inst_if,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, pc_if, inst_if,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
    );
endinterface

// File: rtl/if_fetch_pcgen.sv
// Next-PC select: keep, advance by one instruction, or take a word-aligned redirect target.
module if_fetch_pcgen
    import if_fetch_pkg::*;
(
    input  pc_sel_e     sel_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_next_o
);

    always_comb begin
        pc_next_o = pc_i;
        unique case (sel_i)
            PC_SEL_INC:      pc_next_o = pc_i + PC_INC;
            PC_SEL_REDIRECT: pc_next_o = redirect_pc_i & ~PC_ALIGN_MASK;
            default:         pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/if_fetch.sv
// Fetch stage: one outstanding imem request, holds the fetched word until decode
// accepts it; redirects discard any in-flight or held instruction.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    if_fetch_if.master  bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         drop_q, drop_d;
    logic [31:0]  pc_if_q, inst_if_q;
    logic         capture;
    pc_sel_e      pc_sel;

    if_fetch_pcgen u_pcgen (
        .sel_i         (pc_sel),
        .pc_i          (pc_q),
        .redirect_pc_i (redirect_pc_i),
        .pc_next_o     (pc_d)
    );

    // NOTE: every signal gets its default before the case so no path can leave one unassigned (latch).
    always_comb begin
        state_d            = state_q;
        drop_d             = drop_q;
        pc_sel             = PC_SEL_HOLD;
        capture            = 1'b0;
        bus.imem_req_valid = 1'b0;
        bus.if_valid       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (redirect_valid_i) pc_sel = PC_SEL_REDIRECT;
            end
            ST_REQ: begin
                bus.imem_req_valid = 1'b1;
                if (redirect_valid_i) begin
                    pc_sel = PC_SEL_REDIRECT;
                    // An accepted request still has a response in flight; mark it stale.
                    if (bus.imem_req_ready) begin
                        drop_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end else if (bus.imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    drop_d  = 1'b0;
                    state_d = ST_REQ;
                    if (redirect_valid_i) begin
                        pc_sel = PC_SEL_REDIRECT;
                    end else if (!drop_q) begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                    end
                end else if (redirect_valid_i) begin
                    pc_sel = PC_SEL_REDIRECT;
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                bus.if_valid = !redirect_valid_i;
                if (redirect_valid_i) begin
                    pc_sel  = PC_SEL_REDIRECT;
                    state_d = ST_REQ;
                end else if (bus.id_ready) begin
                    pc_sel  = PC_SEL_INC;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            drop_q    <= 1'b0;
            pc_if_q   <= RESET_PC;
            inst_if_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            if (capture) begin
                pc_if_q   <= pc_q;
                inst_if_q <= bus.imem_rsp_data;
            end
        end
    end

    assign bus.imem_req_addr = pc_q;
    assign bus.pc_if         = pc_if_q;
    assign bus.inst_if       = inst_if_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed vector bench for if_fetch: table of per-cycle inputs/expected outputs
// plus a hand-written mid-WAIT reset sequence.
module tb_if_fetch;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        rspv;
        logic [31:0] rdata;
        logic        idr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_if;
        logic [31:0] e_pcif;
        logic [31:0] e_inst;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    int          n_cmp = 0;
    int          n_err = 0;
    vec_t        vecs[$];

    if_fetch_if bus ();

    if_fetch #(.RESET_PC(32'h8000_0000)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy, input logic rspv,
                       input logic [31:0] rdata, input logic idr, input logic e_req,
                       input logic [31:0] e_addr, input logic e_if, input logic [31:0] e_pcif,
                       input logic [31:0] e_inst);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rspv = rspv; v.rdata = rdata; v.idr = idr;
        v.e_req = e_req; v.e_addr = e_addr; v.e_if = e_if; v.e_pcif = e_pcif; v.e_inst = e_inst;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy,
                         input logic rspv, input logic [31:0] rdata, input logic idr);
        redirect_valid     = rv;
        redirect_pc        = rpc;
        bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = rspv;
        bus.imem_rsp_data  = rdata;
        bus.id_ready       = idr;
    endtask

    task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_if, input logic [31:0] e_pcif, input logic [31:0] e_inst);
        check({tag, ".req_valid"}, {31'd0, bus.imem_req_valid}, {31'd0, e_req});
        check({tag, ".req_addr"}, bus.imem_req_addr, e_addr);
        check({tag, ".if_valid"}, {31'd0, bus.if_valid}, {31'd0, e_if});
        check({tag, ".pc_if"}, bus.pc_if, e_pcif);
        check({tag, ".inst_if"}, bus.inst_if, e_inst);
    endtask

    initial begin
        bit found;

        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

        //  rv  rpc           rdy   rspv  rdata         idr | req   addr          if    pc_if         inst
        add(0, 32'h0,         1, 0, 32'h0,         0, 0, 32'h8000_0000, 0, 32'h8000_0000, 32'h0);
        add(0, 32'h0,         1, 0, 32'h0,         0, 1, 32'h8000_0000, 0, 32'h8000_0000, 32'h0);
        add(0, 32'h0,         0, 1, 32'h0000_0013, 0, 0, 32'h8000_0000, 0, 32'h8000_0000, 32'h0);
        for (int k = 0; k < 5; k++)
            add(0, 32'h0,     0, 0, 32'h0,         0, 0, 32'h8000_0000, 1, 32'h8000_0000, 32'h0000_0013);
        add(0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h8000_0000, 1, 32'h8000_0000, 32'h0000_0013);
        add(0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h8000_0004, 0, 32'h8000_0000, 32'h0000_0013);
        add(0, 32'h0,         1, 0, 32'h0,         0, 1, 32'h8000_0004, 0, 32'h8000_0000, 32'h0000_0013);
        add(1, 32'h8000_1000, 0, 0, 32'h0,         0, 0, 32'h8000_0004, 0, 32'h8000_0000, 32'h0000_0013);
        add(0, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, 0, 32'h8000_1000, 0, 32'h8000_0000, 32'h0000_0013);
        add(0, 32'h0,         1, 0, 32'h0,         0, 1, 32'h8000_1000, 0, 32'h8000_0000, 32'h0000_0013);
        add(0, 32'h0,         0, 1, 32'h0010_0093, 0, 0, 32'h8000_1000, 0, 32'h8000_0000, 32'h0000_0013);
        add(1, 32'h8000_2002, 0, 0, 32'h0,         1, 0, 32'h8000_1000, 0, 32'h8000_1000, 32'h0010_0093);
        add(0, 32'h0,         1, 0, 32'h0,         0, 1, 32'h8000_2000, 0, 32'h8000_1000, 32'h0010_0093);
        add(0, 32'h0,         0, 1, 32'h0020_0113, 0, 0, 32'h8000_2000, 0, 32'h8000_1000, 32'h0010_0093);
        add(0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h8000_2000, 1, 32'h8000_2000, 32'h0020_0113);
        add(1, 32'hFFFF_FFFC, 1, 0, 32'h0,         0, 1, 32'h8000_2004, 0, 32'h8000_2000, 32'h0020_0113);
        add(0, 32'h0,         0, 1, 32'h1111_1111, 0, 0, 32'hFFFF_FFFC, 0, 32'h8000_2000, 32'h0020_0113);
        add(0, 32'h0,         1, 0, 32'h0,         0, 1, 32'hFFFF_FFFC, 0, 32'h8000_2000, 32'h0020_0113);
        add(0, 32'h0,         0, 1, 32'h0030_0193, 0, 0, 32'hFFFF_FFFC, 0, 32'h8000_2000, 32'h0020_0113);
        add(0, 32'h0,         0, 0, 32'h0,         1, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0030_0193);
        add(0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h0000_0000, 0, 32'hFFFF_FFFC, 32'h0030_0193);
        add(0, 32'h0,         1, 0, 32'h0,         0, 1, 32'h0000_0000, 0, 32'hFFFF_FFFC, 32'h0030_0193);
        add(1, 32'h8000_3000, 0, 1, 32'h0000_0099, 0, 0, 32'h0000_0000, 0, 32'hFFFF_FFFC, 32'h0030_0193);
        add(0, 32'h0,         0, 1, 32'h0000_0055, 0, 1, 32'h8000_3000, 0, 32'hFFFF_FFFC, 32'h0030_0193);
        add(1, 32'h8000_4000, 0, 0, 32'h0,         0, 1, 32'h8000_3000, 0, 32'hFFFF_FFFC, 32'h0030_0193);
        add(0, 32'h0,         1, 0, 32'h0,         0, 1, 32'h8000_4000, 0, 32'hFFFF_FFFC, 32'h0030_0193);
        add(0, 32'h0,         0, 1, 32'h0040_0213, 0, 0, 32'h8000_4000, 0, 32'hFFFF_FFFC, 32'h0030_0193);
        add(0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h8000_4000, 1, 32'h8000_4000, 32'h0040_0213);

        // Outputs while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check_outputs("in_reset", 1'b0, 32'h8000_0000, 1'b0, 32'h8000_0000, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            drive(vecs[i].rv, vecs[i].rpc, vecs[i].rdy, vecs[i].rspv, vecs[i].rdata, vecs[i].idr);
            #5;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                          vecs[i].e_if, vecs[i].e_pcif, vecs[i].e_inst);
        end

        // Reset asserted mid-WAIT, then a stale response pulse after release.
        @(posedge clk); #1 drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        @(posedge clk); #1 drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_outputs("async_rst", 1'b0, 32'h8000_0000, 1'b0, 32'h8000_0000, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b1, 32'hCAFE_BABE, 1'b1);
        #4 check_outputs("post_rst_idle", 1'b0, 32'h8000_0000, 1'b0, 32'h8000_0000, 32'h0);
        @(posedge clk); #1 drive(1'b0, '0, 1'b0, 1'b1, 32'hCAFE_BABE, 1'b1);
        #4 check_outputs("post_rst_req", 1'b1, 32'h8000_0000, 1'b0, 32'h8000_0000, 32'h0);

        // Clean fetch after reset; bounded wait for the instruction to appear.
        @(posedge clk); #1 drive(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        @(posedge clk); #1 drive(1'b0, '0, 1'b0, 1'b1, 32'h0050_0293, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            @(posedge clk); #1 drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
            #4 if (bus.if_valid) found = 1'b1;
        end
        check("post_rst_fetch_seen", {31'd0, found}, 32'd1);
        check("post_rst_fetch.pc_if", bus.pc_if, 32'h8000_0000);
        check("post_rst_fetch.inst_if", bus.inst_if, 32'h0050_0293);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
